riscv_muldiv: RTL and testbench
===============================

# riscv_muldiv

Iterative 32-bit multiply/divide unit implementing the RV32M operations. It sits beside the ALU in the execute stage and is fed the same rs1/rs2 operands (A, B) from the register-file read ports. It returns a result with a start/busy/done handshake so the core can stall while the unit works. All operations take a fixed latency, computed one bit per cycle.

## Interface
- XLEN, 32, operand/result width; iteration count equals XLEN.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- op  input  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- A  input  XLEN  rs1 operand (dividend / multiplicand).
- B  input  XLEN  rs2 operand (divisor / multiplier).
- busy  output  1  high while an operation is in flight (CALC, FIX).
- done  output  1  single-cycle pulse; result valid in that cycle.
- result  output  XLEN  last completed result, held until the next done.

## Operation
- States: IDLE, CALC, FIX, DONE.
  - IDLE/DONE with start=1 → CALC. A, B and op are captured; inputs are don't-care afterwards.
  - CALC runs for XLEN cycles with counter 0..XLEN-1, then → FIX.
  - FIX → DONE unconditionally.
  - DONE with start=0 → IDLE.
- start is ignored while busy=1; no queueing.
- Capture stage:
  - Records operand signs: A is signed for MULH, MULHSU, DIV, REM; B is signed for MULH, DIV, REM.
  - Replaces signed operands by their magnitudes.
- CALC, multiply:
  - Shift-add on magnitudes into a 2·XLEN product register.
- CALC, divide:
  - Restoring division on magnitudes.
  - Quotient and remainder are XLEN-bit registers; partial remainder is XLEN+1 bits.
- FIX, multiply:
  - Negate the 2·XLEN product when sign(A) xor sign(B).
  - MUL selects the low half; MULH/MULHSU/MULHU select the high half.
- FIX, divide:
  - Negate the quotient when sign(A) xor sign(B); negate the remainder when sign(A).
- FIX special cases, which override the iterative result:
  - B=0: DIV/DIVU → all-ones; REM/REMU → captured A.
  - DIV with A=0x80000000 and B=0xFFFFFFFF: quotient 0x80000000; REM gives 0.
- result register loads in FIX and is stable from DONE onward.
- No exceptions or flags; arithmetic wraps modulo 2^XLEN.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, busy=0, done=0, result=0, counter=0, internal registers cleared.
- Cycle numbering: start=1 sampled at end of cycle 0.
  - Cycles 1..XLEN: CALC, busy=1.
  - Cycle XLEN+1: FIX, busy=1.
  - Cycle XLEN+2: DONE, busy=0, done=1.
- Latency is XLEN+2 = 34 cycles for every op, including special cases.
- Back-to-back: start=1 in the DONE cycle begins a new op. Cycle 1 of the new op follows directly; done pulses exactly once per op.
- Reset asserted mid-operation aborts immediately: no done pulse, result=0. A start during reset is lost.
- Reset deassertion is synchronised externally; the first start is sampled at the first clk edge after rst=1.

## Structure
- Shared package muldiv_pkg:
  - md_op_e enum (the eight funct3 codes).
  - md_state_e enum (IDLE, CALC, FIX, DONE).
  - Constants MD_LATENCY = XLEN+2 and MD_DIVZERO_Q = all-ones.
- Sub-module muldiv_fix: combinational sign-correction, special-case override and half-select. It is instantiated once in FIX and unit-tested standalone.
- Top module holds the FSM, counter, and operand/product/quotient registers.

## Test plan
- MUL A=5, B=10, start in cycle 0 → busy cycles 1-33, done=1 in cycle 34 with result=0x00000032. Result held afterwards.
- MULH A=0x80000000, B=0x80000000 → 0x40000000.
  - MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU A=0xFFFFFFFF, B=0xFFFFFFFF → 0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU A=10, B=5 → 0x00000002.
- DIV A=5, B=0 → 0xFFFFFFFF; REMU A=5, B=0 → 0x00000005.
  - DIV A=0x80000000, B=0xFFFFFFFF → 0x80000000; REM same → 0.
  - All at latency 34.
- Handshake and reset:
  - start pulsed in cycles 5 and 20 of an op → ignored, single done at cycle 34.
  - start in the DONE cycle → second done exactly 34 cycles later.
  - rst=0 at cycle 10 → busy=0, result=0 immediately, no done pulse.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN = 32;
  localparam int MD_LATENCY = XLEN + 2;
  localparam int MD_CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MD_DIVZERO_Q = '1;
  localparam logic [XLEN-1:0] MD_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // funct3 encodings of the RV32M instructions
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } md_state_e;

  // rs1 is treated as signed for these ops
  function automatic logic op_a_signed(md_op_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  // rs2 is treated as signed for these ops
  function automatic logic op_b_signed(md_op_e op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

  // funct3[2] separates the divide family from the multiply family
  function automatic logic op_is_div(md_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_fix.sv
// Final-cycle correction: applies operand signs to the magnitude results,
// overrides divide-by-zero and signed-overflow cases, selects the output half.
module muldiv_fix
  import muldiv_pkg::*;
(
  input  md_op_e            op,
  input  logic              a_sign,
  input  logic              b_sign,
  input  logic [XLEN-1:0]   a_raw,
  input  logic [XLEN-1:0]   b_raw,
  input  logic [2*XLEN-1:0] prod,
  input  logic [XLEN-1:0]   quo,
  input  logic [XLEN-1:0]   rem,
  output logic [XLEN-1:0]   result
);

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic              div_zero;
  logic              div_ovf;

  // Sign correction, special-case override and result selection
  always_comb begin
    // NOTE: every output of a combinational block gets a value before any branch, otherwise a latch is inferred.
    result   = '0;
    prod_fix = (a_sign ^ b_sign) ? -prod : prod;
    quo_fix  = (a_sign ^ b_sign) ? -quo : quo;
    rem_fix  = a_sign ? -rem : rem;
    div_zero = (b_raw == '0);
    div_ovf  = (op == MD_DIV || op == MD_REM) && (a_raw == MD_INT_MIN) && (b_raw == '1);
    case (op)
      MD_MUL:                        result = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU: begin
        if (div_zero)     result = MD_DIVZERO_Q;
        else if (div_ovf) result = MD_INT_MIN;
        else              result = quo_fix;
      end
      MD_REM, MD_REMU: begin
        if (div_zero)     result = a_raw;
        else if (div_ovf) result = '0;
        else              result = rem_fix;
      end
      default:            result = '0;
    endcase
  end

endmodule

// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, fixed latency of
// XLEN+2 cycles from the start sample to the done pulse.
module riscv_muldiv
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [MD_CNT_W-1:0] CNT_LAST = MD_CNT_W'(XLEN - 1);

  md_state_e         state_q;
  logic [MD_CNT_W-1:0] cnt_q;
  md_op_e            op_q;
  logic              a_sign_q, b_sign_q;
  logic [XLEN-1:0]   a_raw_q, b_raw_q;
  logic [XLEN-1:0]   a_mag_q, b_mag_q;
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN-1:0]   quo_q, rem_q;

  md_op_e            op_in;
  logic              a_sign_in, b_sign_in;
  logic [XLEN-1:0]   a_mag_in, b_mag_in;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_part;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   fix_result;

  // Operand capture: record signs and reduce signed operands to magnitudes
  assign op_in     = md_op_e'(op);
  assign a_sign_in = op_a_signed(op_in) & A[XLEN-1];
  assign b_sign_in = op_b_signed(op_in) & B[XLEN-1];
  assign a_mag_in  = a_sign_in ? -A : A;
  assign b_mag_in  = b_sign_in ? -B : B;

  // One shift-add step: add multiplicand to the upper half when the current multiplier bit is set
  assign mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_mag_q} : '0);

  // One restoring-division step: bring down the next dividend bit and trial-subtract
  assign div_part = {rem_q, quo_q[XLEN-1]};
  assign div_diff = div_part - {1'b0, b_mag_q};
  assign div_ge   = (div_part >= {1'b0, b_mag_q});

  muldiv_fix u_fix (
    .op     (op_q),
    .a_sign (a_sign_q),
    .b_sign (b_sign_q),
    .a_raw  (a_raw_q),
    .b_raw  (b_raw_q),
    .prod   (prod_q),
    .quo    (quo_q),
    .rem    (rem_q),
    .result (fix_result)
  );

  // Control FSM with registered handshake outputs and the iterative datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: every register, datapath included, is reset so an aborted op leaves no stale state behind.
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= MD_MUL;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      a_raw_q  <= '0;
      b_raw_q  <= '0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      prod_q   <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            state_q  <= ST_CALC;
            busy     <= 1'b1;
            cnt_q    <= '0;
            op_q     <= op_in;
            a_sign_q <= a_sign_in;
            b_sign_q <= b_sign_in;
            a_raw_q  <= A;
            b_raw_q  <= B;
            a_mag_q  <= a_mag_in;
            b_mag_q  <= b_mag_in;
            prod_q   <= {{XLEN{1'b0}}, b_mag_in};
            quo_q    <= a_mag_in;
            rem_q    <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (op_is_div(op_q)) begin
            rem_q <= div_ge ? div_diff[XLEN-1:0] : div_part[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], div_ge};
          end else begin
            prod_q <= {mul_sum, prod_q[XLEN-1:1]};
          end
          if (cnt_q == CNT_LAST) state_q <= ST_FIX;
        end
        ST_FIX: begin
          result  <= fix_result;
          state_q <= ST_DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_muldiv.sv
// Self-checking bench for riscv_muldiv: vector table through a result
// scoreboard, plus handshake, back-to-back and mid-op reset sequences.
module tb_riscv_muldiv;
  import muldiv_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] A, B;
  logic            busy, done;
  logic [XLEN-1:0] result;

  riscv_muldiv dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    md_op_e          op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
  } vec_t;

  vec_t            vecs[$];
  logic [XLEN-1:0] exp_q[$];
  int              checks = 0;
  int              errors = 0;
  int              done_seen = 0;

  // Count done pulses independently of the per-op wait loop
  always @(posedge clk) if (done) done_seen <= done_seen + 1;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(string n, md_op_e o, logic [XLEN-1:0] a, logic [XLEN-1:0] b, logic [XLEN-1:0] e);
    vec_t v;
    v.name = n; v.op = o; v.a = a; v.b = b; v.exp = e;
    return v;
  endfunction

  // Called at a negedge (cycle 0); returns at the negedge of cycle 1
  task automatic issue(input md_op_e o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] e);
    start = 1'b1; op = o; A = a; B = b;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom_range(7));
    A = $urandom;
    B = $urandom;
  endtask

  // Waits for done from cycle 1, optionally pulsing start at two cycles; checks latency, busy and result
  task automatic wait_done(input string name, input int pulse1, input int pulse2);
    int lat = 1;
    bit seen = 1'b0;
    bit busy_ok = 1'b1;
    logic [XLEN-1:0] e;
    while (!seen && lat <= 60) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (lat <= MD_LATENCY - 1 && !busy) busy_ok = 1'b0;
        if (lat == pulse1 || lat == pulse2) begin
          start = 1'b1;
          op = 3'($urandom_range(7));
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        lat++;
      end
    end
    start = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done within 60 cycles, expected at cycle %0d", name, MD_LATENCY);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    check({name, " latency"}, 32'(lat), 32'(MD_LATENCY));
    check({name, " busy window"}, 32'(busy_ok), 32'd1);
    check({name, " busy at done"}, 32'(busy), 32'd0);
    e = exp_q.pop_front();
    check({name, " result"}, result, e);
  endtask

  initial begin
    int d0;
    rst = 1'b0; start = 1'b0; op = '0; A = '0; B = '0;

    vecs.push_back(mkv("MUL 5*10",          MD_MUL,    32'd5,        32'd10,       32'h0000_0032));
    vecs.push_back(mkv("MUL -3*7",          MD_MUL,    32'hFFFF_FFFD, 32'd7,       32'hFFFF_FFEB));
    vecs.push_back(mkv("MULH min*min",      MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000));
    vecs.push_back(mkv("MULH -1*-1",        MD_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000));
    vecs.push_back(mkv("MULHSU -1*max",     MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    vecs.push_back(mkv("MULHSU -2*3",       MD_MULHSU, 32'hFFFF_FFFE, 32'd3,       32'hFFFF_FFFF));
    vecs.push_back(mkv("MULHU max*max",     MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE));
    vecs.push_back(mkv("DIV -7/2",          MD_DIV,    32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD));
    vecs.push_back(mkv("REM -7/2",          MD_REM,    32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF));
    vecs.push_back(mkv("DIV 7/-2",          MD_DIV,    32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD));
    vecs.push_back(mkv("REM 7/-2",          MD_REM,    32'd7,        32'hFFFF_FFFE, 32'h0000_0001));
    vecs.push_back(mkv("DIVU 10/5",         MD_DIVU,   32'd10,       32'd5,        32'h0000_0002));
    vecs.push_back(mkv("REMU 100/7",        MD_REMU,   32'd100,      32'd7,        32'h0000_0002));
    vecs.push_back(mkv("DIV 5/0",           MD_DIV,    32'd5,        32'd0,        32'hFFFF_FFFF));
    vecs.push_back(mkv("DIVU max/0",        MD_DIVU,   32'hFFFF_FFFF, 32'd0,       32'hFFFF_FFFF));
    vecs.push_back(mkv("REM -5/0",          MD_REM,    32'hFFFF_FFFB, 32'd0,       32'hFFFF_FFFB));
    vecs.push_back(mkv("REMU 5/0",          MD_REMU,   32'd5,        32'd0,        32'h0000_0005));
    vecs.push_back(mkv("DIV min/-1",        MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000));
    vecs.push_back(mkv("REM min/-1",        MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000));

    // Reset state
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Vector table, each followed by a hold check one cycle after done
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      wait_done(vecs[i].name, -1, -1);
      @(negedge clk);
      check({vecs[i].name, " held"}, result, vecs[i].exp);
      check({vecs[i].name, " done cleared"}, 32'(done), 32'd0);
    end

    // start pulses while busy are ignored: one done only
    d0 = done_seen;
    issue(MD_MUL, 32'd5, 32'd10, 32'h0000_0032);
    wait_done("ignored starts", 5, 20);
    repeat (40) @(negedge clk);
    check("ignored starts done count", 32'(done_seen - d0), 32'd1);
    check("ignored starts idle", 32'(busy), 32'd0);

    // Back-to-back: new start in the DONE cycle
    d0 = done_seen;
    issue(MD_DIVU, 32'd10, 32'd5, 32'h0000_0002);
    wait_done("b2b first", -1, -1);
    issue(MD_REMU, 32'd100, 32'd7, 32'h0000_0002);
    wait_done("b2b second", -1, -1);
    repeat (3) @(negedge clk);
    check("b2b done count", 32'(done_seen - d0), 32'd2);

    // Reset at cycle 10 aborts; a start during reset is lost
    d0 = done_seen;
    issue(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort result", result, 32'd0);
    check("abort done", 32'(done), 32'd0);
    exp_q.delete();
    start = 1'b1; op = MD_MUL; A = 32'd3; B = 32'd3;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("start in reset lost", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    check("abort no done", 32'(done_seen - d0), 32'd0);

    // Recovery after reset
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    wait_done("after reset", -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
